// File: rtl/spart_pkg.sv
// spart_pkg: shared state encoding, SPART register addresses and baud divisor helper
package spart_pkg;
  typedef enum logic [2:0] {LD_LO, LD_HI, IDLE, RD_RX, WR_TX, GAP} state_t;
  localparam logic [1:0] IOADDR_BUF    = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  localparam logic [1:0] IOADDR_DB_LO  = 2'b10;
  localparam logic [1:0] IOADDR_DB_HI  = 2'b11;
  function automatic logic [15:0] baud_div(input int clk_hz, input int baud);
    return 16'(clk_hz / (16 * baud) - 1);
  endfunction
endpackage

// File: rtl/spart_echo_fifo.sv
// spart_echo_fifo: small synchronous FIFO that holds received bytes until TX can take them
module spart_echo_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic [$clog2(D):0]   count,
  output logic                 full,
  output logic                 empty
);
  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;
  assign full    = count_q == D[CW-1:0];
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign dout    = mem_q[rd_q];
  // pointers wrap naturally since D is a power of two; the separate count keeps full/empty distinct
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  // storage is written only on an accepted push, so it needs no reset
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/spart_echo_driver.sv
// spart_echo_driver: programs the SPART baud divisor from br_cfg and echoes RX bytes back to TX; define SPART_DRV_UPCASE_EN to upcase echoed a..z
module spart_echo_driver
  import spart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD0      = 4800,
  parameter int BAUD1      = 9600,
  parameter int BAUD2      = 19200,
  parameter int BAUD3      = 38400,
  parameter int DATA_W     = 8,
  parameter int ECHO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  br_cfg,
  input  logic                        rda,
  input  logic                        tbr,
  output logic                        iocs,
  output logic                        iorw,
  output logic [1:0]                  ioaddr,
  inout  wire  [DATA_W-1:0]           databus,
  output logic [$clog2(ECHO_DEPTH):0] fifo_count,
  output logic                        loading
);
  state_t            state_q, state_d;
  logic [1:0]        sync1_q, sync_q, cfg_q;
  logic              last_wr_q, full, empty, push, pop, rx_ok, tx_ok;
  logic [15:0]       div_now;
  logic [7:0]        tx_byte;
  logic [DATA_W-1:0] head, wdata;
  function automatic logic [15:0] div_of(input logic [1:0] sel);
    return sel == 2'd0 ? baud_div(CLK_HZ, BAUD0) :
           sel == 2'd1 ? baud_div(CLK_HZ, BAUD1) :
           sel == 2'd2 ? baud_div(CLK_HZ, BAUD2) : baud_div(CLK_HZ, BAUD3);
  endfunction
  // switch synchroniser, unreset so the first reload after reset already sees the settled switches
  always_ff @(posedge clk) begin
    sync1_q <= br_cfg;
    sync_q  <= sync1_q;
  end
  // state, config captured while LD_LO drives the low byte, and round-robin history
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= LD_LO;
      cfg_q     <= 2'b00;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cfg_q     <= state_q == LD_LO ? sync_q : cfg_q;
      last_wr_q <= state_q == RD_RX ? 1'b0 : state_q == WR_TX ? 1'b1 : last_wr_q;
    end
  // sequencing: reload wins in IDLE, then round-robin between read and write when both are ready
  always_comb begin
    rx_ok   = rda && !full;
    tx_ok   = tbr && !empty;
    state_d = state_q == LD_LO ? LD_HI :
              state_q == GAP   ? IDLE  :
              state_q != IDLE  ? GAP   :
              sync_q != cfg_q  ? LD_LO :
              rx_ok && tx_ok   ? (last_wr_q ? RD_RX : WR_TX) :
              rx_ok            ? RD_RX :
              tx_ok            ? WR_TX : IDLE;
  end
  // bus drive decoded from state; reset forces the idle bus values while rst is low
  always_comb begin
    iocs    = rst && state_q != IDLE && state_q != GAP;
    iorw    = !(iocs && state_q != RD_RX);
    ioaddr  = !iocs ? IOADDR_STATUS : state_q == LD_LO ? IOADDR_DB_LO :
              state_q == LD_HI ? IOADDR_DB_HI : IOADDR_BUF;
    loading = rst && (state_q == LD_LO || state_q == LD_HI);
    div_now = div_of(state_q == LD_LO ? sync_q : cfg_q);
    wdata   = state_q == LD_LO ? DATA_W'(div_now[7:0]) :
              state_q == LD_HI ? DATA_W'(div_now[15:8]) : DATA_W'(tx_byte);
  end
`ifdef SPART_DRV_UPCASE_EN
  assign tx_byte = (head[7:0] >= 8'h61 && head[7:0] <= 8'h7a) ? head[7:0] - 8'h20 : head[7:0];
`else
  assign tx_byte = head[7:0];
`endif
  assign push    = iocs && state_q == RD_RX;
  assign pop     = iocs && state_q == WR_TX;
  assign databus = (iocs && !iorw) ? wdata : 'z;
  spart_echo_fifo #(.W(DATA_W), .D(ECHO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (DATA_W'(databus[7:0])),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_spart_echo_driver.sv
// tb_spart_echo_driver: directed stimulus with a transaction-level echo model checked every cycle
module tb_spart_echo_driver;
  localparam int CLK_HZ = 50_000_000;
  localparam int DEPTH  = 4;
  localparam int K_IDLE = 0, K_LDLO = 1, K_LDHI = 2, K_RD = 3, K_WR = 4, K_GAP = 5;
  logic       clk = 0, rst = 0, rda = 0, tbr = 0;
  logic [1:0] br_cfg = 2'b01;
  logic       iocs, iorw, loading;
  logic [1:0] ioaddr;
  logic [2:0] fifo_count;
  wire  [7:0] databus;
  int checks = 0, failures = 0;
  logic [7:0] rx_tab [16] = '{8'h41, 8'h61, 8'h7B, 8'h60, 8'h7A, 8'h5B, 8'h62, 8'h30,
                              8'h71, 8'h20, 8'h7E, 8'h55, 8'h68, 8'h69, 8'h6A, 8'h6B};
`ifdef SPART_DRV_UPCASE_EN
  logic [7:0] exp_echo [4] = '{8'h41, 8'h7B, 8'h60, 8'h5A};
`else
  logic [7:0] exp_echo [4] = '{8'h61, 8'h7B, 8'h60, 8'h7A};
`endif
  int rx_idx = 0;
  int baud [4] = '{4800, 9600, 19200, 38400};
  int cur = K_LDLO;
  int plan [$];
  logic [7:0] q [$];
  logic [1:0] s1 = 2'b00, s2 = 2'b00, m_cfg = 2'b00;
  bit m_last_wr = 1'b1, m_rx, m_tx, exp_cs, prev_rw;
  int alt_bad, nrd;

  spart_echo_driver dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .rda        (rda),
    .tbr        (tbr),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus    (databus),
    .fifo_count (fifo_count),
    .loading    (loading)
  );

  assign databus = (iocs && iorw) ? rx_tab[rx_idx % 16] : 'z;
  always #5 clk = ~clk;

  function automatic int bdiv(input logic [1:0] c);
    return CLK_HZ / (16 * baud[c]) - 1;
  endfunction

  function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef SPART_DRV_UPCASE_EN
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
    return b;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_acc(input logic rw, input logic [1:0] addr, input string nm);
    int n = 0;
    while (!(iocs && iorw == rw && ioaddr == addr) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_seen"}, n < 60, 1);
  endtask

  task automatic wait_any(input string nm);
    int n = 0;
    while (!iocs && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_seen"}, n < 60, 1);
  endtask

  // model: each closing edge applies the finished access, and an idle cycle plans the next access + gap
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      m_cfg     = 2'b00;
      m_last_wr = 1'b1;
      cur       = K_LDLO;
      plan      = '{K_LDHI, K_GAP};
    end else begin
      if (cur == K_RD) begin
        q.push_back(rx_tab[rx_idx % 16]);
        rx_idx <= rx_idx + 1;
        m_last_wr = 1'b0;
      end
      if (cur == K_WR) begin
        void'(q.pop_front());
        m_last_wr = 1'b1;
      end
      if (cur == K_LDLO) m_cfg = s2;
      if (cur == K_IDLE) begin
        m_rx = rda && q.size() < DEPTH;
        m_tx = tbr && q.size() > 0;
        if (s2 != m_cfg) plan = '{K_LDLO, K_LDHI, K_GAP};
        else if (m_rx || m_tx)
          plan = '{(m_rx && m_tx) ? (m_last_wr ? K_RD : K_WR) : (m_rx ? K_RD : K_WR), K_GAP};
      end
      cur = plan.size() > 0 ? plan.pop_front() : K_IDLE;
    end
    s2 = s1;
    s1 = br_cfg;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_iocs", iocs, 0);
      chk("rst_iorw", iorw, 1);
      chk("rst_ioaddr", ioaddr, 2'b01);
      chk("rst_count", fifo_count, 0);
      chk("rst_loading", loading, 0);
    end else begin
      exp_cs = cur inside {K_LDLO, K_LDHI, K_RD, K_WR};
      chk("m_iocs", iocs, exp_cs);
      chk("m_iorw", iorw, !(cur inside {K_LDLO, K_LDHI, K_WR}));
      chk("m_ioaddr", ioaddr, cur == K_LDLO ? 2 : cur == K_LDHI ? 3 : exp_cs ? 0 : 1);
      chk("m_count", fifo_count, q.size());
      chk("m_loading", loading, cur == K_LDLO || cur == K_LDHI);
      if (cur == K_LDLO) chk("m_div_lo", databus, bdiv(s2) & 255);
      if (cur == K_LDHI) chk("m_div_hi", databus, bdiv(m_cfg) >> 8);
      if (cur == K_WR && q.size() > 0) chk("m_echo", databus, echo_of(q[0]));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_iocs", iocs, 0);
    chk("reset_ioaddr", ioaddr, 2'b01);
    chk("reset_count", fifo_count, 0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("boot_lo_addr", ioaddr, 2'b10);
    chk("boot_lo_rw", iorw, 0);
    chk("boot_lo_data", databus, 8'h44);
    chk("boot_loading", loading, 1);
    @(negedge clk);
    chk("boot_hi_addr", ioaddr, 2'b11);
    chk("boot_hi_data", databus, 8'h01);
    @(negedge clk);
    chk("boot_gap", iocs, 0);
    @(negedge clk);
    chk("boot_idle", iocs, 0);
    chk("boot_idle_addr", ioaddr, 2'b01);
    repeat (3) @(negedge clk);
    br_cfg = 2'b11;
    wait_acc(0, 2'b10, "cfg11_lo");
    chk("cfg11_lo_data", databus, 8'h50);
    chk("cfg11_count", fifo_count, 0);
    @(negedge clk);
    chk("cfg11_hi_data", databus, 8'h00);
    @(negedge clk);
    rda = 1;
    tbr = 1;
    wait_acc(1, 2'b00, "loop_rd");
    rda = 0;
    @(negedge clk);
    chk("loop_gap", iocs, 0);
    chk("loop_count1", fifo_count, 1);
    wait_acc(0, 2'b00, "loop_wr");
    chk("loop_wr_data", databus, 8'h41);
    @(negedge clk);
    chk("loop_count0", fifo_count, 0);
    tbr = 0;
    rda = 1;
    repeat (20) @(negedge clk);
    chk("full_count", fifo_count, 4);
    nrd = 0;
    repeat (12) begin
      @(negedge clk);
      if (iocs) nrd++;
    end
    chk("full_no_read", nrd, 0);
    rda = 0;
    tbr = 1;
    for (int i = 0; i < 4; i++) begin
      wait_acc(0, 2'b00, "drain_wr");
      chk("drain_data", databus, exp_echo[i]);
      @(negedge clk);
    end
    chk("drain_count", fifo_count, 0);
    tbr = 0;
    rda = 1;
    for (int i = 0; i < 2; i++) begin
      wait_acc(1, 2'b00, "prefill_rd");
      @(negedge clk);
    end
    tbr = 1;
    alt_bad = 0;
    for (int i = 0; i < 8; i++) begin
      wait_any("alt");
      if (i > 0 && iorw == prev_rw) alt_bad++;
      prev_rw = iorw;
      @(negedge clk);
      chk("alt_gap", iocs, 0);
    end
    chk("alternation", alt_bad, 0);
    rda = 0;
    repeat (12) @(negedge clk);
    chk("alt_drained", fifo_count, 0);
    tbr = 0;
    rda = 1;
    wait_acc(1, 2'b00, "mid_rd");
    br_cfg = 2'b00;
    rda = 0;
    wait_acc(0, 2'b10, "mid_reload");
    chk("mid_lo_data", databus, 8'h8A);
    chk("mid_count_kept", fifo_count, 1);
    @(negedge clk);
    chk("mid_hi_data", databus, 8'h02);
    rda = 1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    #1;
    chk("midrst_iocs", iocs, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ioaddr", ioaddr, 2'b01);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    rda = 0;
    @(negedge clk);
    chk("rerst_lo_addr", ioaddr, 2'b10);
    chk("rerst_lo_data", databus, 8'h8A);
    @(negedge clk);
    chk("rerst_hi_data", databus, 8'h02);
    @(negedge clk);
    br_cfg = 2'b01;
    wait_acc(0, 2'b10, "tog_lo");
    chk("tog_lo_data", databus, 8'h44);
    br_cfg = 2'b10;
    @(negedge clk);
    chk("tog_hi_kept", databus, 8'h01);
    wait_acc(0, 2'b10, "tog_reload");
    chk("tog_reload_lo", databus, 8'hA1);
    @(negedge clk);
    chk("tog_reload_hi", databus, 8'h00);
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
